detector_de_pulso: RTL and testbench

//  Two-channel pulse-sequence detector; sits behind two synchronous pulse sources (a, b).
//  - Converts rising edges on a/b into events A, B, or AB.
//  - Flags alternating patterns: A-B-A on seq_a, B-A-B on seq_b, each as a 1-cycle pulse.
//  - Stale partial patterns are discarded after an inactivity timeout.

---
 rtl/detector_de_pulso_pkg.sv | 36 +++
 rtl/detector_de_pulso_seq_fsm.sv | 58 +++++
 rtl/detector_de_pulso.sv | 91 +++++++++
 tb/tb_detector_de_pulso.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/detector_de_pulso_pkg.sv
// -----------------------------------------------------------------------------
// detector_de_pulso_pkg
// Shared types for the two-channel pulse-sequence detector:
//   seq_state_t : state of one alternating-pattern FSM (IDLE, S1, S2)
//   pulse_ev_t  : per-cycle event class derived from the rising edges of a/b
//   classify()  : maps the two rising-edge strobes onto a pulse_ev_t
// -----------------------------------------------------------------------------
package detector_de_pulso_pkg;

  typedef enum logic [1:0] {
    IDLE,
    S1,
    S2
  } seq_state_t;

  typedef enum logic [1:0] {
    EV_NONE,
    EV_A,
    EV_B,
    EV_AB
  } pulse_ev_t;

  // Simultaneous edges form their own class (EV_AB) rather than counting as
  // either channel, so the pattern FSMs never see A and B in the same cycle.
  function automatic pulse_ev_t classify(input logic rise_a, input logic rise_b);
    pulse_ev_t ev;
    unique case ({rise_a, rise_b})
      2'b10:   ev = EV_A;
      2'b01:   ev = EV_B;
      2'b11:   ev = EV_AB;
      default: ev = EV_NONE;
    endcase
    return ev;
  endfunction

endpackage

// File: rtl/detector_de_pulso_seq_fsm.sv
// -----------------------------------------------------------------------------
// seq_fsm
// Detects the alternating pattern first,second,first and flags it with a
// registered one-cycle pulse. Overlapping patterns are allowed: the closing
// "first" event also starts the next pattern.
// Ports:
//   clk       in  clock, rising edge
//   reset     in  synchronous active-low reset
//   ev_first  in  single-cycle strobe: event of the pattern's outer channel
//   ev_second in  single-cycle strobe: event of the pattern's middle channel
//   ev_clear  in  return to IDLE (simultaneous event or inactivity timeout)
//   hit       out registered pulse when the pattern completes
// ev_first and ev_second are never high together (the classifier guarantees it).
// -----------------------------------------------------------------------------
module seq_fsm
  import detector_de_pulso_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic ev_first,
  input  logic ev_second,
  input  logic ev_clear,
  output logic hit
);

  seq_state_t state_q, state_d;
  logic       hit_q, hit_d;

  // NOTE: every signal assigned here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    hit_d   = 1'b0;
    if (ev_clear) begin
      state_d = IDLE;
    end else if (ev_first) begin
      hit_d   = (state_q == S2);
      state_d = S1;
    end else if (ev_second) begin
      state_d = (state_q == S1) ? S2 : IDLE;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update
  // from the same pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      hit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hit_q   <= hit_d;
    end
  end

  assign hit = hit_q;

endmodule

// File: rtl/detector_de_pulso.sv
// -----------------------------------------------------------------------------
// detector_de_pulso
// Two-channel pulse-sequence detector. Rising edges on a/b become events
// A, B or AB; pattern A,B,A pulses seq_a and B,A,B pulses seq_b. Partial
// patterns are dropped after MAX_GAP cycles without any event.
// Parameters:
//   MAX_GAP  idle cycles after which both pattern FSMs return to IDLE (>=1)
// Ports:
//   clk    in  clock, rising edge
//   reset  in  synchronous active-low reset (wins over any simultaneous event)
//   a      in  pulse input A, synchronous to clk
//   b      in  pulse input B, synchronous to clk
//   seq_a  out registered one-cycle pulse when A,B,A completes
//   seq_b  out registered one-cycle pulse when B,A,B completes
// -----------------------------------------------------------------------------
module detector_de_pulso
  import detector_de_pulso_pkg::*;
#(
  parameter int MAX_GAP = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic a,
  input  logic b,
  output logic seq_a,
  output logic seq_b
);

  localparam int               CNT_W   = $clog2(MAX_GAP + 1);
  localparam logic [CNT_W-1:0] GAP_MAX = CNT_W'(MAX_GAP);
  localparam logic [CNT_W-1:0] GAP_ONE = CNT_W'(1);

  logic             a_q, b_q;
  logic             rise_a, rise_b;
  pulse_ev_t        ev;
  logic [CNT_W-1:0] gap_q, gap_d;
  logic             timeout;
  logic             ev_clear;

  // Edge detect: a level held high produces a single event.
  assign rise_a = a & ~a_q;
  assign rise_b = b & ~b_q;
  assign ev     = classify(rise_a, rise_b);

  // Gap counter saturates at MAX_GAP. The timeout fires on the edge where the
  // counter arrives at MAX_GAP, so exactly MAX_GAP idle cycles discard a
  // partial pattern while MAX_GAP-1 idle cycles keep it. Any event in the
  // cycle overrides the timeout because timeout requires EV_NONE.
  always_comb begin
    gap_d = gap_q;
    if (ev != EV_NONE) begin
      gap_d = '0;
    end else if (gap_q != GAP_MAX) begin
      gap_d = gap_q + GAP_ONE;
    end
  end

  assign timeout  = (ev == EV_NONE) && (gap_d == GAP_MAX);
  assign ev_clear = (ev == EV_AB) || timeout;

  always_ff @(posedge clk) begin
    if (!reset) begin
      a_q   <= 1'b0;
      b_q   <= 1'b0;
      gap_q <= '0;
    end else begin
      a_q   <= a;
      b_q   <= b;
      gap_q <= gap_d;
    end
  end

  seq_fsm u_fsm_aba (
    .clk      (clk),
    .reset    (reset),
    .ev_first (ev == EV_A),
    .ev_second(ev == EV_B),
    .ev_clear (ev_clear),
    .hit      (seq_a)
  );

  seq_fsm u_fsm_bab (
    .clk      (clk),
    .reset    (reset),
    .ev_first (ev == EV_B),
    .ev_second(ev == EV_A),
    .ev_clear (ev_clear),
    .hit      (seq_b)
  );

endmodule

// File: tb/tb_detector_de_pulso.sv
// -----------------------------------------------------------------------------
// tb_detector_de_pulso
// Directed per-cycle vectors {reset, a, b, expected seq_a, expected seq_b}
// followed by a randomized run against a behavioural reference model.
// Inputs change on the falling edge; outputs are sampled 1 ns after the
// rising edge that consumed the vector.
// -----------------------------------------------------------------------------
module tb_detector_de_pulso;

  localparam int MAX_GAP = 8;

  typedef struct {
    int tid;
    bit rst_n;
    bit a;
    bit b;
    bit exp_a;
    bit exp_b;
  } vec_t;

  logic clk;
  logic reset;
  logic a;
  logic b;
  logic seq_a;
  logic seq_b;

  int checks;
  int failures;

  vec_t vecs[$];

  // reference model state for the random phase
  int m_aba;
  int m_bab;
  int m_gap;
  bit m_pa;
  bit m_pb;

  detector_de_pulso #(.MAX_GAP(MAX_GAP)) dut (
    .clk  (clk),
    .reset(reset),
    .a    (a),
    .b    (b),
    .seq_a(seq_a),
    .seq_b(seq_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void add(input int tid, input bit rst_n, input bit ia, input bit ib,
                              input bit ea, input bit eb);
    vec_t v;
    v.tid = tid; v.rst_n = rst_n; v.a = ia; v.b = ib; v.exp_a = ea; v.exp_b = eb;
    vecs.push_back(v);
  endfunction

  function automatic void add_idle(input int tid, input int n);
    for (int i = 0; i < n; i++) add(tid, 1, 0, 0, 0, 0);
  endfunction

  task automatic drive(input bit rst_n, input bit ia, input bit ib);
    @(negedge clk);
    reset = rst_n;
    a     = ia;
    b     = ib;
    @(posedge clk);
    #1;
  endtask

  // One random-phase cycle: drive, then advance the model with what the edge
  // sampled and compare both outputs.
  task automatic rstep(input bit na, input bit nb);
    bit ra, rb, ea, eb;
    drive(1, na, nb);
    ra = na && !m_pa;
    rb = nb && !m_pb;
    m_pa = na;
    m_pb = nb;
    ea = 0;
    eb = 0;
    if (ra && rb) begin
      m_aba = 0; m_bab = 0; m_gap = 0;
    end else if (ra) begin
      if (m_aba == 2) ea = 1;
      m_aba = 1;
      m_bab = (m_bab == 1) ? 2 : 0;
      m_gap = 0;
    end else if (rb) begin
      if (m_bab == 2) eb = 1;
      m_bab = 1;
      m_aba = (m_aba == 1) ? 2 : 0;
      m_gap = 0;
    end else begin
      if (m_gap < MAX_GAP) m_gap++;
      if (m_gap == MAX_GAP) begin
        m_aba = 0; m_bab = 0;
      end
    end
    check("rand_seq_a", seq_a, ea);
    check("rand_seq_b", seq_b, eb);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    a        = 1'b0;
    b        = 1'b0;

    // 1 reset: pulses under reset are ignored, also a would-be completing A
    add(1, 0, 1, 0, 0, 0);
    add(1, 0, 0, 1, 0, 0);
    add(1, 0, 1, 0, 0, 0);
    add(1, 1, 0, 0, 0, 0);
    add(1, 1, 1, 0, 0, 0);
    add(1, 1, 0, 0, 0, 0);
    add(1, 1, 0, 1, 0, 0);
    add(1, 1, 0, 0, 0, 0);
    add(1, 0, 1, 0, 0, 0);   // reset beats the completing A
    add(1, 1, 0, 0, 0, 0);

    // 2 basic A,g,B,g,g,A
    add(2, 0, 0, 0, 0, 0);
    add(2, 1, 1, 0, 0, 0);
    add(2, 1, 0, 0, 0, 0);
    add(2, 1, 0, 1, 0, 0);
    add_idle(2, 2);
    add(2, 1, 1, 0, 1, 0);
    add(2, 1, 0, 0, 0, 0);

    // 3 overlap A,B,A,B,A with one idle cycle each
    add(3, 0, 0, 0, 0, 0);
    add(3, 1, 1, 0, 0, 0); add(3, 1, 0, 0, 0, 0);
    add(3, 1, 0, 1, 0, 0); add(3, 1, 0, 0, 0, 0);
    add(3, 1, 1, 0, 1, 0); add(3, 1, 0, 0, 0, 0);
    add(3, 1, 0, 1, 0, 1); add(3, 1, 0, 0, 0, 0);
    add(3, 1, 1, 0, 1, 0); add(3, 1, 0, 0, 0, 0);

    // 4 clear: A,B,AB,A -> nothing; then B,A -> seq_a
    add(4, 0, 0, 0, 0, 0);
    add(4, 1, 1, 0, 0, 0); add(4, 1, 0, 0, 0, 0);
    add(4, 1, 0, 1, 0, 0); add(4, 1, 0, 0, 0, 0);
    add(4, 1, 1, 1, 0, 0); add(4, 1, 0, 0, 0, 0);
    add(4, 1, 1, 0, 0, 0); add(4, 1, 0, 0, 0, 0);
    add(4, 1, 0, 1, 0, 0); add(4, 1, 0, 0, 0, 0);
    add(4, 1, 1, 0, 1, 0); add(4, 1, 0, 0, 0, 0);

    // 5 timeout: MAX_GAP idle cycles drop the pattern, MAX_GAP-1 keep it
    add(5, 0, 0, 0, 0, 0);
    add(5, 1, 1, 0, 0, 0); add(5, 1, 0, 0, 0, 0);
    add(5, 1, 0, 1, 0, 0);
    add_idle(5, MAX_GAP);
    add(5, 1, 1, 0, 0, 0); add(5, 1, 0, 0, 0, 0);
    add(5, 0, 0, 0, 0, 0);
    add(5, 1, 1, 0, 0, 0); add(5, 1, 0, 0, 0, 0);
    add(5, 1, 0, 1, 0, 0);
    add_idle(5, MAX_GAP - 1);
    add(5, 1, 1, 0, 1, 0); add(5, 1, 0, 0, 0, 0);

    // 6 held level: a high 5 cycles is one event
    add(6, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) add(6, 1, 1, 0, 0, 0);
    add(6, 1, 0, 0, 0, 0);
    add(6, 1, 0, 1, 0, 0); add(6, 1, 0, 0, 0, 0);
    add(6, 1, 1, 0, 1, 0); add(6, 1, 0, 0, 0, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].rst_n, vecs[i].a, vecs[i].b);
      check($sformatf("t%0d_row%0d_seq_a", vecs[i].tid, i), seq_a, vecs[i].exp_a);
      check($sformatf("t%0d_row%0d_seq_b", vecs[i].tid, i), seq_b, vecs[i].exp_b);
    end

    // random phase: reset DUT and model, then 10 us of sparse pulses
    drive(0, 0, 0);
    check("rand_reset_seq_a", seq_a, 1'b0);
    check("rand_reset_seq_b", seq_b, 1'b0);
    m_aba = 0; m_bab = 0; m_gap = 0; m_pa = 0; m_pb = 0;
    begin
      int cyc;
      cyc = 0;
      while (cyc < 1000) begin
        int idle;
        idle = int'($urandom_range(2, 1));
        for (int k = 0; k < idle; k++) rstep(0, 0);
        rstep($urandom_range(2, 0) == 0, $urandom_range(2, 0) == 0);
        cyc += idle + 1;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
